// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle instruction-fetch sequencer. Drives the pc block, runs the
// instruction-memory req/ack handshake and presents fetched words to decode.
module fetch_ctrl #(
  parameter int CountWidth = 32
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [31:0]           pc_in,
  output logic                  pc_enable,
  output logic                  pc_mode,
  output logic [31:0]           pc_jmp_addr,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  input  logic                  jmp_valid,
  input  logic [31:0]           jmp_addr,
  input  logic                  halt,
  output logic [CountWidth-1:0] fetch_count
);

  localparam logic PC_MODE_INCREMENT = 1'b0;
  localparam logic PC_MODE_JUMP      = 1'b1;
  localparam logic [CountWidth-1:0] CountOne = {{(CountWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                  state_reg, state_next, resume_state;
  logic                    jmp_pend_reg, jmp_pend_next;
  logic [31:0]             jmp_pend_addr_reg, jmp_pend_addr_next;
  logic [31:0]             instr_reg, instr_next;
  logic [31:0]             instr_pc_reg, instr_pc_next;
  logic [CountWidth-1:0]   fetch_count_reg, fetch_count_next;
  logic                    jmp_go, inc_go;
  logic [31:0]             jmp_tgt;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_reg         <= IDLE;
      jmp_pend_reg      <= 1'b0;
      jmp_pend_addr_reg <= '0;
      instr_reg         <= '0;
      instr_pc_reg      <= '0;
      fetch_count_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      jmp_pend_reg      <= jmp_pend_next;
      jmp_pend_addr_reg <= jmp_pend_addr_next;
      instr_reg         <= instr_next;
      instr_pc_reg      <= instr_pc_next;
      fetch_count_reg   <= fetch_count_next;
    end
  end

  // halt only gates entry into FETCH; it never cancels a request or a valid word
  assign resume_state = halt ? IDLE : FETCH;

  always_comb begin
    state_next         = state_reg;
    jmp_pend_next      = jmp_pend_reg;
    jmp_pend_addr_next = jmp_pend_addr_reg;
    instr_next         = instr_reg;
    instr_pc_next      = instr_pc_reg;
    fetch_count_next   = fetch_count_reg;
    jmp_go             = 1'b0;
    inc_go             = 1'b0;
    jmp_tgt            = '0;
    case (state_reg)
      IDLE: begin
        if (jmp_valid) begin
          jmp_go  = 1'b1;
          jmp_tgt = jmp_addr;
        end
        state_next = resume_state;
      end
      FETCH: begin
        if (mem_ack) begin
          if (jmp_valid || jmp_pend_reg) begin
            // The memory transaction completes normally but its data is dropped.
            jmp_go        = 1'b1;
            jmp_tgt       = jmp_valid ? jmp_addr : jmp_pend_addr_reg;
            jmp_pend_next = 1'b0;
            state_next    = resume_state;
          end else begin
            instr_next    = mem_rdata;
            instr_pc_next = pc_in;
            state_next    = HOLD;
          end
        end else if (jmp_valid) begin
          jmp_pend_next      = 1'b1;
          jmp_pend_addr_next = jmp_addr;
        end
      end
      HOLD: begin
        if (jmp_valid) begin
          jmp_go     = 1'b1;
          jmp_tgt    = jmp_addr;
          state_next = resume_state;
        end else if (instr_ready) begin
          inc_go           = 1'b1;
          fetch_count_next = fetch_count_reg + CountOne;
          state_next       = resume_state;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // pc controls are suppressed while reset is held so the pc block sees no pulse.
  assign pc_enable   = (jmp_go || inc_go) && !res;
  assign pc_mode     = (jmp_go && !res) ? PC_MODE_JUMP : PC_MODE_INCREMENT;
  assign pc_jmp_addr = (jmp_go && !res) ? jmp_tgt : '0;

  assign mem_req     = (state_reg == FETCH);
  assign mem_addr    = pc_in;
  assign instr_valid = (state_reg == HOLD);
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: a pc register and memory/decode stimulus around the DUT,
// checked against a transaction-level model of fetch address, fetched word and count.
module tb_fetch_ctrl;

  localparam logic [31:0] PC_INIT_ADDR = 32'h0000_0080;
  localparam int          CW           = 4;

  logic          clk;
  logic          res;
  logic [31:0]   pc_in;
  logic          pc_enable;
  logic          pc_mode;
  logic [31:0]   pc_jmp_addr;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          jmp_valid;
  logic [31:0]   jmp_addr;
  logic          halt;
  logic [CW-1:0] fetch_count;

  int            checks;
  int            failures;
  int            exp_count;
  logic [31:0]   exp_addr;

  fetch_ctrl #(.CountWidth(CW)) dut (
    .clk(clk), .res(res), .pc_in(pc_in),
    .pc_enable(pc_enable), .pc_mode(pc_mode), .pc_jmp_addr(pc_jmp_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .halt(halt), .fetch_count(fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The pc block the controller drives: increment by 4 or load the jump target.
  always_ff @(posedge clk or posedge res) begin
    if (res) pc_in <= PC_INIT_ADDR;
    else if (pc_enable) pc_in <= pc_mode ? pc_jmp_addr : pc_in + 32'd4;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) step();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL wait_req: mem_req got %b required 1 within 20 cycles", mem_req);
    end
  endtask

  task automatic ack_data(output logic [31:0] d);
    d = $urandom;
    mem_ack = 1'b1;
    mem_rdata = d;
    step();
    mem_ack = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    exp_count++;
    exp_addr = exp_addr + 32'd4;
    $display("handshake pc=%h count=%0d", exp_addr - 32'd4, exp_count);
  endtask

  task automatic test_reset();
    res = 1'b1; mem_ack = 0; mem_rdata = 0; instr_ready = 0;
    jmp_valid = 0; jmp_addr = 0; halt = 0;
    step();
    jmp_valid = 1'b1; jmp_addr = 32'h1234;
    #1;
    checks++;
    if (mem_req !== 0 || instr_valid !== 0) begin
      failures++;
      $display("FAIL reset_moore: mem_req=%b instr_valid=%b required 0/0", mem_req, instr_valid);
    end
    checks++;
    if (pc_enable !== 0 || pc_mode !== 0 || pc_jmp_addr !== 0) begin
      failures++;
      $display("FAIL reset_pc: en=%b mode=%b addr=%h required 0/0/0", pc_enable, pc_mode, pc_jmp_addr);
    end
    checks++;
    if (fetch_count !== 0 || instr !== 0 || instr_pc !== 0) begin
      failures++;
      $display("FAIL reset_regs: count=%0d instr=%h instr_pc=%h required 0", fetch_count, instr, instr_pc);
    end
    jmp_valid = 1'b0;
    res = 1'b0;
    #1;
    checks++;
    if (mem_req !== 0) begin
      failures++;
      $display("FAIL reset_idle: mem_req got %b required 0", mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1 || mem_addr !== PC_INIT_ADDR) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h required 1/%h", mem_req, mem_addr, PC_INIT_ADDR);
    end
    exp_addr = PC_INIT_ADDR;
    exp_count = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      wait_req();
      checks++;
      if (mem_addr !== exp_addr) begin
        failures++;
        $display("FAIL seq_addr: got %h required %h", mem_addr, exp_addr);
      end
      if (k > 0) step();
      ack_data(d);
      checks++;
      if (instr_valid !== 1 || instr !== d || instr_pc !== exp_addr) begin
        failures++;
        $display("FAIL seq_instr: v=%b instr=%h pc=%h required 1/%h/%h", instr_valid, instr, instr_pc, d, exp_addr);
      end
      accept();
      checks++;
      if (fetch_count !== CW'(exp_count)) begin
        failures++;
        $display("FAIL seq_count: got %0d required %0d", fetch_count, exp_count);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    wait_req();
    ack_data(d);
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (instr_valid !== 1 || instr !== d || instr_pc !== exp_addr || mem_req !== 0) begin
        failures++;
        $display("FAIL stall_hold: v=%b instr=%h pc=%h req=%b required 1/%h/%h/0",
                 instr_valid, instr, instr_pc, mem_req, d, exp_addr);
      end
    end
    accept();
    checks++;
    if (mem_req !== 1 || mem_addr !== exp_addr || fetch_count !== CW'(exp_count)) begin
      failures++;
      $display("FAIL stall_release: req=%b addr=%h count=%0d required 1/%h/%0d",
               mem_req, mem_addr, fetch_count, exp_addr, exp_count);
    end
  endtask

  task automatic test_jump_hold();
    logic [31:0] d;
    wait_req();
    ack_data(d);
    jmp_valid = 1'b1; jmp_addr = 32'h100; instr_ready = 1'b1;
    #1;
    checks++;
    if (pc_enable !== 1 || pc_mode !== 1 || pc_jmp_addr !== 32'h100) begin
      failures++;
      $display("FAIL jhold_pc: en=%b mode=%b addr=%h required 1/1/00000100", pc_enable, pc_mode, pc_jmp_addr);
    end
    step();
    jmp_valid = 1'b0; instr_ready = 1'b0;
    checks++;
    if (fetch_count !== CW'(exp_count) || mem_req !== 1 || mem_addr !== 32'h100 || instr_valid !== 0) begin
      failures++;
      $display("FAIL jhold_next: count=%0d req=%b addr=%h v=%b required %0d/1/00000100/0",
               fetch_count, mem_req, mem_addr, instr_valid, exp_count);
    end
    exp_addr = 32'h100;
  endtask

  task automatic test_jump_fetch();
    logic [31:0] a;
    wait_req();
    a = mem_addr;
    jmp_valid = 1'b1; jmp_addr = 32'h200;
    #1;
    checks++;
    if (pc_enable !== 0) begin
      failures++;
      $display("FAIL jfetch_deferred: pc_enable got %b required 0", pc_enable);
    end
    step();
    jmp_valid = 1'b0;
    step();
    jmp_valid = 1'b1; jmp_addr = 32'h300;
    step();
    jmp_valid = 1'b0;
    checks++;
    if (mem_req !== 1 || mem_addr !== a) begin
      failures++;
      $display("FAIL jfetch_stable: req=%b addr=%h required 1/%h", mem_req, mem_addr, a);
    end
    mem_ack = 1'b1; mem_rdata = $urandom;
    #1;
    checks++;
    if (pc_enable !== 1 || pc_mode !== 1 || pc_jmp_addr !== 32'h300) begin
      failures++;
      $display("FAIL jfetch_pc: en=%b mode=%b addr=%h required 1/1/00000300", pc_enable, pc_mode, pc_jmp_addr);
    end
    step();
    mem_ack = 1'b0;
    checks++;
    if (instr_valid !== 0 || mem_req !== 1 || mem_addr !== 32'h300) begin
      failures++;
      $display("FAIL jfetch_next: v=%b req=%b addr=%h required 0/1/00000300", instr_valid, mem_req, mem_addr);
    end
    exp_addr = 32'h300;
  endtask

  task automatic test_jump_same_cycle();
    logic [31:0] t;
    wait_req();
    t = $urandom & 32'h0000_FFFC;
    mem_ack = 1'b1; mem_rdata = $urandom; jmp_valid = 1'b1; jmp_addr = t;
    #1;
    checks++;
    if (pc_enable !== 1 || pc_jmp_addr !== t) begin
      failures++;
      $display("FAIL jsame_pc: en=%b addr=%h required 1/%h", pc_enable, pc_jmp_addr, t);
    end
    step();
    mem_ack = 1'b0; jmp_valid = 1'b0;
    checks++;
    if (instr_valid !== 0 || mem_addr !== t) begin
      failures++;
      $display("FAIL jsame_next: v=%b addr=%h required 0/%h", instr_valid, mem_addr, t);
    end
    exp_addr = t;
  endtask

  task automatic test_halt();
    logic [31:0] d;
    wait_req();
    halt = 1'b1;
    repeat (2) step();
    checks++;
    if (mem_req !== 1 || mem_addr !== exp_addr) begin
      failures++;
      $display("FAIL halt_fetch_kept: req=%b addr=%h required 1/%h", mem_req, mem_addr, exp_addr);
    end
    ack_data(d);
    repeat (2) step();
    checks++;
    if (instr_valid !== 1 || instr !== d) begin
      failures++;
      $display("FAIL halt_valid_kept: v=%b instr=%h required 1/%h", instr_valid, instr, d);
    end
    accept();
    repeat (2) step();
    checks++;
    if (mem_req !== 0 || fetch_count !== CW'(exp_count)) begin
      failures++;
      $display("FAIL halt_idle: req=%b count=%0d required 0/%0d", mem_req, fetch_count, exp_count);
    end
    jmp_valid = 1'b1; jmp_addr = 32'h40;
    #1;
    checks++;
    if (pc_enable !== 1 || pc_mode !== 1 || pc_jmp_addr !== 32'h40) begin
      failures++;
      $display("FAIL halt_jump_pc: en=%b mode=%b addr=%h required 1/1/00000040", pc_enable, pc_mode, pc_jmp_addr);
    end
    step();
    jmp_valid = 1'b0;
    checks++;
    if (mem_req !== 0) begin
      failures++;
      $display("FAIL halt_jump_idle: req got %b required 0", mem_req);
    end
    halt = 1'b0;
    step();
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL halt_resume: req=%b addr=%h required 1/00000040", mem_req, mem_addr);
    end
    exp_addr = 32'h40;
  endtask

  task automatic test_random();
    logic [31:0] a, d, tgt;
    bit pend;
    for (int n = 0; n < 40; n++) begin
      wait_req();
      checks++;
      if (mem_addr !== exp_addr) begin
        failures++;
        $display("FAIL rnd_addr: got %h required %h", mem_addr, exp_addr);
      end
      a = mem_addr;
      pend = 0;
      tgt = 0;
      for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
        if ($urandom_range(0, 3) == 0) begin
          tgt = $urandom & 32'h0000_FFFC;
          jmp_valid = 1'b1; jmp_addr = tgt; pend = 1;
        end
        step();
        jmp_valid = 1'b0;
        checks++;
        if (mem_req !== 1 || mem_addr !== a) begin
          failures++;
          $display("FAIL rnd_stable: req=%b addr=%h required 1/%h", mem_req, mem_addr, a);
        end
      end
      d = $urandom;
      mem_ack = 1'b1; mem_rdata = d;
      if ($urandom_range(0, 4) == 0) begin
        tgt = $urandom & 32'h0000_FFFC;
        jmp_valid = 1'b1; jmp_addr = tgt; pend = 1;
      end
      step();
      mem_ack = 1'b0; jmp_valid = 1'b0;
      if (pend) begin
        checks++;
        if (instr_valid !== 0 || mem_req !== 1 || mem_addr !== tgt) begin
          failures++;
          $display("FAIL rnd_squash: v=%b req=%b addr=%h required 0/1/%h", instr_valid, mem_req, mem_addr, tgt);
        end
        exp_addr = tgt;
        $display("squashed fetch pc=%h redirect=%h", a, tgt);
      end else begin
        checks++;
        if (instr_valid !== 1 || instr !== d || instr_pc !== a) begin
          failures++;
          $display("FAIL rnd_instr: v=%b instr=%h pc=%h required 1/%h/%h", instr_valid, instr, instr_pc, d, a);
        end
        repeat ($urandom_range(0, 3)) begin
          step();
          checks++;
          if (instr_valid !== 1 || instr !== d || mem_req !== 0) begin
            failures++;
            $display("FAIL rnd_hold: v=%b instr=%h req=%b required 1/%h/0", instr_valid, instr, mem_req, d);
          end
        end
        if ($urandom_range(0, 4) == 0) begin
          tgt = $urandom & 32'h0000_FFFC;
          jmp_valid = 1'b1; jmp_addr = tgt; instr_ready = 1'($urandom_range(0, 1));
          step();
          jmp_valid = 1'b0; instr_ready = 1'b0;
          exp_addr = tgt;
          $display("squashed held pc=%h redirect=%h", a, tgt);
        end else begin
          accept();
        end
        checks++;
        if (fetch_count !== CW'(exp_count)) begin
          failures++;
          $display("FAIL rnd_count: got %0d required %0d", fetch_count, CW'(exp_count));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    for (int i = 0; i < 40 && (exp_count % 16) != 15; i++) begin
      wait_req();
      ack_data(d);
      accept();
    end
    checks++;
    if (fetch_count !== 4'd15) begin
      failures++;
      $display("FAIL wrap_max: got %0d required 15", fetch_count);
    end
    wait_req();
    ack_data(d);
    accept();
    checks++;
    if (fetch_count !== 4'd0) begin
      failures++;
      $display("FAIL wrap_zero: got %0d required 0", fetch_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_count = 0;
    exp_addr = PC_INIT_ADDR;
    test_reset();
    test_sequential();
    test_stall();
    test_jump_hold();
    test_jump_fetch();
    test_jump_same_cycle();
    test_halt();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
